// File: rtl/eh2_lsu_ecc_wbq.sv
// eh2_lsu_ecc_wbq
//   Single-ECC correction writeback queue. Captures SEC-corrected DCCM bank
//   words from DC5, merges repeat corrections to the same address, and
//   writes them back to the DCCM write port through a req/gnt handshake.
//   Requests that are starved for too long raise wb_urgent. Completed
//   repairs are counted in a saturating counter.
//
//   State | Meaning
//   ------+-----------------------------------------------
//   IDLE  | queue empty, no write request
//   REQ   | head entry presented on wb_addr/wb_data, wb_req=1
//
// Ports
//   clk, rst                      clock, async active-high reset
//   ecc_disable                   blocks new captures (draining continues)
//   cap_valid_dc5/cap_lo/cap_hi   capture qualifier and bank selects
//   cap_addr_*_dc5, sec_data_*    word addresses and corrected data
//   wb_gnt                        write port granted this cycle
//   clr_count                     clears ecc_corr_count and ecc_overflow
//   wb_req, wb_urgent             write request / starvation escalation
//   wb_addr, wb_data              head entry (wb_addr[1:0] forced to 0)
//   wbq_full, wbq_empty           fewer than 2 free entries / no entries
//   ecc_corr_count, ecc_overflow  repairs written / sticky capture drop
module eh2_lsu_ecc_wbq #(
    parameter int DCCM_BITS       = 16,
    parameter int DCCM_DATA_WIDTH = 32,
    parameter int DEPTH           = 4,
    parameter int STARVE_CYCLES   = 8,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ecc_disable,
    input  logic                       cap_valid_dc5,
    input  logic                       cap_lo_dc5,
    input  logic                       cap_hi_dc5,
    input  logic [DCCM_BITS-1:0]       cap_addr_lo_dc5,
    input  logic [DCCM_BITS-1:0]       cap_addr_hi_dc5,
    input  logic [DCCM_DATA_WIDTH-1:0] sec_data_lo_dc5,
    input  logic [DCCM_DATA_WIDTH-1:0] sec_data_hi_dc5,
    input  logic                       wb_gnt,
    input  logic                       clr_count,
    output logic                       wb_req,
    output logic                       wb_urgent,
    output logic [DCCM_BITS-1:0]       wb_addr,
    output logic [DCCM_DATA_WIDTH-1:0] wb_data,
    output logic                       wbq_full,
    output logic                       wbq_empty,
    output logic [CNT_WIDTH-1:0]       ecc_corr_count,
    output logic                       ecc_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_CYCLES + 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                     state, state_nxt;
    logic [DCCM_BITS-1:0]       q_addr [DEPTH];
    logic [DCCM_DATA_WIDTH-1:0] q_data [DEPTH];
    logic [PW-1:0]              rd_ptr, wr_ptr;
    logic [CW-1:0]              count, count_nxt;
    logic [SW-1:0]              starve;

    logic          pop, cap_qual, accept;
    logic          lo_hit, hi_hit, new_lo, new_hi;
    logic [PW-1:0] lo_idx, hi_idx;
    logic [CW-1:0] n_new, n_acc, free_slots;

    assign pop      = (state == REQ) && wb_gnt;
    assign cap_qual = cap_valid_dc5 && !ecc_disable && (cap_lo_dc5 || cap_hi_dc5);

    // Merge lookup over live entries; the head leaving this cycle is excluded
    // so a same-address capture on the grant cycle becomes a fresh entry.
    always_comb begin : merge_lookup
        logic [PW-1:0] offs;
        logic          live;
        offs   = '0;
        live   = 1'b0;
        lo_hit = 1'b0;
        hi_hit = 1'b0;
        lo_idx = '0;
        hi_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rd_ptr;
            live = ({1'b0, offs} < count) && !(pop && (PW'(i) == rd_ptr));
            if (live && cap_lo_dc5 && (q_addr[i] == cap_addr_lo_dc5)) begin
                lo_hit = 1'b1;
                lo_idx = PW'(i);
            end
            if (live && cap_hi_dc5 && (q_addr[i] == cap_addr_hi_dc5)) begin
                hi_hit = 1'b1;
                hi_idx = PW'(i);
            end
        end
    end

    assign n_new      = CW'(cap_lo_dc5 && !lo_hit) + CW'(cap_hi_dc5 && !hi_hit);
    assign free_slots = CW'(DEPTH) - count + CW'(pop);
    // All-or-nothing: a capture that does not fit leaves the queue untouched.
    assign accept     = cap_qual && (n_new <= free_slots);
    assign n_acc      = accept ? n_new : '0;
    assign new_lo     = accept && cap_lo_dc5 && !lo_hit;
    assign new_hi     = accept && cap_hi_dc5 && !hi_hit;
    assign count_nxt  = count + n_acc - CW'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            wbq_full  <= 1'b0;
            wbq_empty <= 1'b1;
        end else begin
            if (accept && cap_lo_dc5 && lo_hit) q_data[lo_idx] <= sec_data_lo_dc5;
            if (accept && cap_hi_dc5 && hi_hit) q_data[hi_idx] <= sec_data_hi_dc5;
            if (new_lo) begin
                q_addr[wr_ptr] <= cap_addr_lo_dc5;
                q_data[wr_ptr] <= sec_data_lo_dc5;
            end
            if (new_hi) begin
                q_addr[new_lo ? wr_ptr + 1'b1 : wr_ptr] <= cap_addr_hi_dc5;
                q_data[new_lo ? wr_ptr + 1'b1 : wr_ptr] <= sec_data_hi_dc5;
            end
            wr_ptr    <= wr_ptr + PW'(n_acc);
            rd_ptr    <= rd_ptr + PW'(pop);
            count     <= count_nxt;
            wbq_full  <= count_nxt > CW'(DEPTH - 2);
            wbq_empty <= count_nxt == '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Looking at count_nxt lets a capture raise wb_req on the following cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (count_nxt != '0) state_nxt = REQ;
            REQ:  if (pop && (count_nxt == '0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve <= '0;
        end else if ((state == REQ) && !wb_gnt) begin
            if (starve < SW'(STARVE_CYCLES)) starve <= starve + 1'b1;
        end else begin
            starve <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ecc_corr_count <= '0;
            ecc_overflow   <= 1'b0;
        end else if (clr_count) begin
            ecc_corr_count <= '0;
            ecc_overflow   <= 1'b0;
        end else begin
            if (pop && (ecc_corr_count != '1)) ecc_corr_count <= ecc_corr_count + 1'b1;
            if (cap_qual && !accept) ecc_overflow <= 1'b1;
        end
    end

    assign wb_req    = (state == REQ);
    assign wb_urgent = (starve >= SW'(STARVE_CYCLES));
    assign wb_addr   = {q_addr[rd_ptr][DCCM_BITS-1:2], 2'b00};
    assign wb_data   = q_data[rd_ptr];

endmodule

// File: tb/tb_eh2_lsu_ecc_wbq.sv
// Testbench for eh2_lsu_ecc_wbq: directed steps, queue-based reference model
// of the writeback queue, immediate-assertion checks every cycle.
module tb_eh2_lsu_ecc_wbq;

    logic        clk = 1'b0;
    logic        rst, ecc_disable, cap_valid, cap_lo, cap_hi, gnt, clr;
    logic [15:0] a_lo, a_hi;
    logic [31:0] d_lo, d_hi;
    logic        wb_req, wb_urgent, wbq_full, wbq_empty, ecc_overflow;
    logic [15:0] wb_addr, ecc_corr_count;
    logic [31:0] wb_data;

    eh2_lsu_ecc_wbq dut (
        .clk(clk), .rst(rst), .ecc_disable(ecc_disable),
        .cap_valid_dc5(cap_valid), .cap_lo_dc5(cap_lo), .cap_hi_dc5(cap_hi),
        .cap_addr_lo_dc5(a_lo), .cap_addr_hi_dc5(a_hi),
        .sec_data_lo_dc5(d_lo), .sec_data_hi_dc5(d_hi),
        .wb_gnt(gnt), .clr_count(clr),
        .wb_req(wb_req), .wb_urgent(wb_urgent), .wb_addr(wb_addr), .wb_data(wb_data),
        .wbq_full(wbq_full), .wbq_empty(wbq_empty),
        .ecc_corr_count(ecc_corr_count), .ecc_overflow(ecc_overflow)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] qa[$];
    logic [31:0] qd[$];
    int          m_cnt    = 0;
    bit          m_ovf    = 0;
    int          m_starve = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cap(input bit v, input bit lo, input bit hi,
                           input logic [15:0] al, input logic [31:0] dl,
                           input logic [15:0] ah, input logic [31:0] dh);
        cap_valid = v; cap_lo = lo; cap_hi = hi;
        a_lo = al; d_lo = dl; a_hi = ah; d_hi = dh;
    endtask

    // One clock: check outputs against the model, then advance the model with
    // the inputs currently driven.
    task automatic cyc();
        bit m_req, dep;
        int need, free, lo_i, hi_i;
        #1;
        m_req = (qa.size() != 0);
        chk("wb_req", wb_req, m_req);
        chk("wbq_empty", wbq_empty, qa.size() == 0);
        chk("wbq_full", wbq_full, qa.size() > 2);
        chk("wb_urgent", wb_urgent, m_starve >= 8);
        chk("corr_count", ecc_corr_count, m_cnt);
        chk("overflow", ecc_overflow, m_ovf);
        if (m_req) begin
            chk("wb_addr", wb_addr, qa[0] & 16'hfffc);
            chk("wb_data", wb_data, qd[0]);
        end
        dep = m_req && gnt;
        if (cap_valid && !ecc_disable && (cap_lo || cap_hi)) begin
            lo_i = -1;
            hi_i = -1;
            for (int i = (dep ? 1 : 0); i < qa.size(); i++) begin
                if (cap_lo && qa[i] == a_lo) lo_i = i;
                if (cap_hi && qa[i] == a_hi) hi_i = i;
            end
            need = int'(cap_lo && lo_i < 0) + int'(cap_hi && hi_i < 0);
            free = 4 - qa.size() + int'(dep);
            if (need > free) begin
                m_ovf = 1;
            end else begin
                if (lo_i >= 0) qd[lo_i] = d_lo;
                if (hi_i >= 0) qd[hi_i] = d_hi;
                if (cap_lo && lo_i < 0) begin qa.push_back(a_lo); qd.push_back(d_lo); end
                if (cap_hi && hi_i < 0) begin qa.push_back(a_hi); qd.push_back(d_hi); end
            end
        end
        if (dep) begin
            void'(qa.pop_front());
            void'(qd.pop_front());
            if (m_cnt < 65535) m_cnt++;
        end
        if (m_req && !gnt) begin
            if (m_starve < 8) m_starve++;
        end else begin
            m_starve = 0;
        end
        if (clr) begin
            m_cnt = 0;
            m_ovf = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        chk("rst wb_req", wb_req, 1'b0);
        chk("rst wbq_empty", wbq_empty, 1'b1);
        chk("rst wbq_full", wbq_full, 1'b0);
        chk("rst wb_urgent", wb_urgent, 1'b0);
        chk("rst wb_addr", wb_addr, 16'h0);
        chk("rst wb_data", wb_data, 32'h0);
        chk("rst corr_count", ecc_corr_count, 16'h0);
        chk("rst overflow", ecc_overflow, 1'b0);
    endtask

    initial begin
        rst = 1'b1; ecc_disable = 1'b0; gnt = 1'b0; clr = 1'b0;
        set_cap(0, 0, 0, 16'h0, 32'h0, 16'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        cyc();

        // Lo-only capture, grant held high.
        gnt = 1'b1;
        set_cap(1, 1, 0, 16'h0104, 32'hDEADBEEF, 16'h0, 32'h0);
        cyc();
        set_cap(0, 0, 0, 16'h0, 32'h0, 16'h0, 32'h0);
        repeat (3) cyc();

        // Lo+hi capture with a starved port, then grant.
        gnt = 1'b0;
        set_cap(1, 1, 1, 16'h0100, 32'h11110000, 16'h0104, 32'h22220000);
        cyc();
        set_cap(0, 0, 0, 16'h0, 32'h0, 16'h0, 32'h0);
        repeat (10) cyc();
        gnt = 1'b1;
        repeat (2) cyc();
        gnt = 1'b0;
        repeat (2) cyc();

        // Fill, overflow drop, clear.
        set_cap(1, 1, 1, 16'h0010, 32'hA0, 16'h0014, 32'hA1);
        cyc();
        set_cap(1, 1, 1, 16'h0018, 32'hA2, 16'h001C, 32'hA3);
        cyc();
        set_cap(1, 1, 1, 16'h0020, 32'hA4, 16'h0024, 32'hA5);
        cyc();
        set_cap(0, 0, 0, 16'h0, 32'h0, 16'h0, 32'h0);
        repeat (2) cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        gnt = 1'b1;
        repeat (6) cyc();
        gnt = 1'b0;

        // Merge before grant: one write of B.
        set_cap(1, 1, 0, 16'h0200, 32'hAAAA0001, 16'h0, 32'h0);
        cyc();
        set_cap(1, 1, 0, 16'h0200, 32'hBBBB0002, 16'h0, 32'h0);
        cyc();
        set_cap(0, 0, 0, 16'h0, 32'h0, 16'h0, 32'h0);
        cyc();
        gnt = 1'b1;
        cyc();
        gnt = 1'b0;
        repeat (2) cyc();

        // Same address arriving on the grant cycle: two writes, A then B.
        set_cap(1, 1, 0, 16'h0200, 32'hAAAA0003, 16'h0, 32'h0);
        cyc();
        gnt = 1'b1;
        set_cap(1, 1, 0, 16'h0200, 32'hBBBB0004, 16'h0, 32'h0);
        cyc();
        set_cap(0, 0, 0, 16'h0, 32'h0, 16'h0, 32'h0);
        repeat (2) cyc();
        gnt = 1'b0;

        // ecc_disable blocks captures but not draining.
        set_cap(1, 1, 1, 16'h0300, 32'hC0, 16'h0304, 32'hC1);
        cyc();
        ecc_disable = 1'b1;
        set_cap(1, 1, 1, 16'h0400, 32'hD0, 16'h0404, 32'hD1);
        repeat (2) cyc();
        gnt = 1'b1;
        repeat (4) cyc();
        ecc_disable = 1'b0;
        gnt = 1'b0;
        set_cap(0, 0, 0, 16'h0, 32'h0, 16'h0, 32'h0);
        cyc();

        // Reset with three entries pending and wb_req high.
        set_cap(1, 1, 1, 16'h0500, 32'hE0, 16'h0504, 32'hE1);
        cyc();
        set_cap(1, 1, 0, 16'h0508, 32'hE2, 16'h0, 32'h0);
        cyc();
        set_cap(0, 0, 0, 16'h0, 32'h0, 16'h0, 32'h0);
        cyc();
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals();
        qa.delete();
        qd.delete();
        m_cnt = 0;
        m_ovf = 0;
        m_starve = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        gnt = 1'b1;
        set_cap(1, 1, 1, 16'h0600, 32'hF0, 16'h0604, 32'hF1);
        cyc();
        set_cap(0, 0, 0, 16'h0, 32'h0, 16'h0, 32'h0);
        repeat (4) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
